mem_port_arbiter: RTL and testbench

Shares a single-ported 32-bit memory bus between the instruction-fetch requester (I) and the data memory controller requester (D) of the MIPS32 core. Each request is captured into a holding register at grant time and driven to memory until the memory's one-cycle ready pulse. The ready and read data are then returned to the owning requester. Tied requests alternate priority, and a watchdog terminates requests that memory never answers.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D requesters, the shared memory port and the arbiter.
// The arbiter takes the slave view; requesters and memory together take the master view.
interface mem_port_arbiter_if;
    logic        IReadEnable;
    logic [31:0] IAddress;
    logic        DReadEnable;
    logic [3:0]  DWriteEnable;
    logic [31:0] DAddress;
    logic [31:0] DWriteData;
    logic [31:0] MReadData;
    logic        MReady;
    logic [31:0] MAddress;
    logic [31:0] MWriteData;
    logic        MReadEnable;
    logic [3:0]  MWriteEnable;
    logic [31:0] IReadData;
    logic [31:0] DReadData;
    logic        IReady;
    logic        DReady;
    logic        IBusErr;
    logic        DBusErr;

    modport master (
        output IReadEnable, IAddress,
        output DReadEnable, DWriteEnable, DAddress, DWriteData,
        output MReadData, MReady,
        input  MAddress, MWriteData, MReadEnable, MWriteEnable,
        input  IReadData, DReadData, IReady, DReady,
        input  IBusErr, DBusErr
    );

    modport slave (
        input  IReadEnable, IAddress,
        input  DReadEnable, DWriteEnable, DAddress, DWriteData,
        input  MReadData, MReady,
        output MAddress, MWriteData, MReadEnable, MWriteEnable,
        output IReadData, DReadData, IReady, DReady,
        output IBusErr, DBusErr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data (D).
// Requests are latched at grant, held until MReady, and aborted by a watchdog.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        prio;
    logic [7:0]  cnt;
    logic        i_req;
    logic        d_req;
    logic        grant_i;
    logic        grant_d;
    logic        timeout;
    logic        done;

    assign i_req = bus.IReadEnable;
    assign d_req = bus.DReadEnable | (|bus.DWriteEnable);

    assign bus.IReadData = bus.MReadData;
    assign bus.DReadData = bus.MReadData;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        unique case (state)
            IDLE: begin
                // prio=1 means D won last tie, so I goes first now
                if (d_req && (!i_req || !prio)) begin
                    state_next = GNT_D;
                    grant_d    = 1'b1;
                end else if (i_req) begin
                    state_next = GNT_I;
                    grant_i    = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        timeout     = 1'b0;
        done        = 1'b0;
        if (state != IDLE) begin
            timeout = !bus.MReady && (cnt == CNT_LAST);
            done    = bus.MReady || timeout;
        end
        bus.IReady  = (state == GNT_I) && done;
        bus.DReady  = (state == GNT_D) && done;
        bus.IBusErr = (state == GNT_I) && timeout;
        bus.DBusErr = (state == GNT_D) && timeout;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prio             <= 1'b0;
            cnt              <= 8'd0;
            bus.MAddress     <= 32'd0;
            bus.MWriteData   <= 32'd0;
            bus.MReadEnable  <= 1'b0;
            bus.MWriteEnable <= 4'd0;
        end else begin
            if (state == IDLE) begin
                cnt <= 8'd0;
            end else if (!bus.MReady) begin
                cnt <= cnt + 8'd1;
            end

            if (grant_i) begin
                prio             <= 1'b0;
                bus.MAddress     <= bus.IAddress;
                bus.MWriteData   <= 32'd0;
                bus.MReadEnable  <= 1'b1;
                bus.MWriteEnable <= 4'd0;
            end else if (grant_d) begin
                prio             <= 1'b1;
                bus.MAddress     <= bus.DAddress;
                bus.MWriteData   <= bus.DWriteData;
                bus.MReadEnable  <= bus.DReadEnable;
                bus.MWriteEnable <= bus.DWriteEnable;
            end else if (done) begin
                bus.MReadEnable  <= 1'b0;
                bus.MWriteEnable <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed
// scenarios with literal expectations, followed by randomized traffic.
module tb_mem_port_arbiter;
    localparam int T = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, what was latched, how long it has waited.
    int          owner = 0;
    bit          last_d = 1'b0;
    int          age = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_re = 1'b0;
    logic [3:0]  m_we = '0;

    always @(posedge clock) begin : model
        bit ir;
        bit dr;
        ir = bus.IReadEnable;
        dr = bus.DReadEnable || (bus.DWriteEnable != 4'd0);
        if (reset) begin
            owner = 0; last_d = 1'b0; age = 0;
            m_addr = '0; m_wdata = '0; m_re = 1'b0; m_we = '0;
        end else if (owner == 0) begin
            age = 0;
            if (dr && (!ir || !last_d)) begin
                owner = 2; last_d = 1'b1;
                m_addr = bus.DAddress; m_wdata = bus.DWriteData;
                m_re = bus.DReadEnable; m_we = bus.DWriteEnable;
            end else if (ir) begin
                owner = 1; last_d = 1'b0;
                m_addr = bus.IAddress; m_wdata = '0;
                m_re = 1'b1; m_we = '0;
            end
        end else if (bus.MReady || age == T - 1) begin
            owner = 0; m_re = 1'b0; m_we = '0;
        end else begin
            age++;
        end
    end

    always @(negedge clock) begin : compare
        bit fin;
        bit err;
        if (chk_en) begin
            fin = (owner != 0) && (bus.MReady || age == T - 1);
            err = fin && !bus.MReady;
            check("MAddress", bus.MAddress, m_addr);
            check("MWriteData", bus.MWriteData, m_wdata);
            check("MReadEnable", 32'(bus.MReadEnable), 32'(m_re));
            check("MWriteEnable", 32'(bus.MWriteEnable), 32'(m_we));
            check("IReady", 32'(bus.IReady), 32'(fin && owner == 1));
            check("DReady", 32'(bus.DReady), 32'(fin && owner == 2));
            check("IBusErr", 32'(bus.IBusErr), 32'(err && owner == 1));
            check("DBusErr", 32'(bus.DBusErr), 32'(err && owner == 2));
            check("IReadData", bus.IReadData, bus.MReadData);
            check("DReadData", bus.DReadData, bus.MReadData);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic neg();
        @(negedge clock);
    endtask

    initial begin
        bus.IReadEnable = 1'b0; bus.IAddress = '0;
        bus.DReadEnable = 1'b0; bus.DWriteEnable = '0;
        bus.DAddress = '0; bus.DWriteData = '0;
        bus.MReadData = '0; bus.MReady = 1'b0;
        reset = 1'b1;
        step;
        chk_en = 1'b1;
        step;
        reset = 1'b0;
        neg;
        check("rst_MReadEnable", 32'(bus.MReadEnable), 32'd0);
        check("rst_MAddress", bus.MAddress, 32'd0);

        // D write, MReady on 3rd grant cycle
        bus.DWriteEnable = 4'b0011;
        bus.DAddress = 32'h1000_0004;
        bus.DWriteData = 32'hAABB_CCDD;
        step;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) bus.MReady = 1'b1;
            neg;
            check("w_MWriteEnable", 32'(bus.MWriteEnable), 32'h3);
            check("w_MAddress", bus.MAddress, 32'h1000_0004);
            check("w_MWriteData", bus.MWriteData, 32'hAABB_CCDD);
            check("w_DReady", 32'(bus.DReady), 32'(k == 3));
            check("w_IReady", 32'(bus.IReady), 32'd0);
            step;
        end
        bus.MReady = 1'b0;
        bus.DWriteEnable = '0;
        neg;
        check("w_strobes_clear", 32'({bus.MReadEnable, bus.MWriteEnable}), 32'd0);
        step;

        // Both request from reset: D, then I, then D again
        reset = 1'b1;
        step;
        reset = 1'b0;
        bus.IReadEnable = 1'b1; bus.IAddress = 32'h3000_0000;
        bus.DReadEnable = 1'b1; bus.DAddress = 32'h2000_0000;
        step;
        bus.MReady = 1'b1; bus.MReadData = 32'h1111_2222;
        neg;
        check("t1_MAddress", bus.MAddress, 32'h2000_0000);
        check("t1_DReady", 32'(bus.DReady), 32'd1);
        check("t1_IReady", 32'(bus.IReady), 32'd0);
        step;
        bus.MReady = 1'b0; bus.DReadEnable = 1'b0;
        step;
        bus.MReady = 1'b1;
        neg;
        check("t2_MAddress", bus.MAddress, 32'h3000_0000);
        check("t2_IReady", 32'(bus.IReady), 32'd1);
        step;
        bus.MReady = 1'b0; bus.DReadEnable = 1'b1;
        step;
        bus.MReady = 1'b1;
        neg;
        check("t3_MAddress", bus.MAddress, 32'h2000_0000);
        check("t3_DReady", 32'(bus.DReady), 32'd1);
        step;
        bus.MReady = 1'b0; bus.DReadEnable = 1'b0;
        step;
        bus.MReady = 1'b1;
        neg;
        check("t4_IReady", 32'(bus.IReady), 32'd1);
        step;
        bus.MReady = 1'b0; bus.IReadEnable = 1'b0;
        step;

        // I read with the address changing mid-grant
        bus.IReadEnable = 1'b1; bus.IAddress = 32'hBFC0_0000;
        step;
        bus.IAddress = 32'h0;
        neg;
        check("i_MAddress_hold", bus.MAddress, 32'hBFC0_0000);
        step;
        bus.MReady = 1'b1; bus.MReadData = 32'h2408_0001;
        neg;
        check("i_MAddress_done", bus.MAddress, 32'hBFC0_0000);
        check("i_IReady", 32'(bus.IReady), 32'd1);
        check("i_IReadData", bus.IReadData, 32'h2408_0001);
        step;
        bus.MReady = 1'b0; bus.IReadEnable = 1'b0;
        step;

        // Watchdog expiry on a D read, then a stray MReady in IDLE
        bus.DReadEnable = 1'b1; bus.DAddress = 32'h0000_0040;
        step;
        for (int k = 1; k <= T; k++) begin
            neg;
            check("to_DReady", 32'(bus.DReady), 32'(k == T));
            check("to_DBusErr", 32'(bus.DBusErr), 32'(k == T));
            step;
        end
        bus.DReadEnable = 1'b0;
        neg;
        check("to_idle_MReadEnable", 32'(bus.MReadEnable), 32'd0);
        step;
        bus.MReady = 1'b1;
        neg;
        check("stray_DReady", 32'(bus.DReady), 32'd0);
        check("stray_IReady", 32'(bus.IReady), 32'd0);
        step;
        bus.MReady = 1'b0;

        // Reset in GNT_I, MReady the following cycle
        bus.IReadEnable = 1'b1; bus.IAddress = 32'h0000_0100;
        step;
        reset = 1'b1;
        neg;
        check("r_IReady_pre", 32'(bus.IReady), 32'd0);
        step;
        reset = 1'b0; bus.IReadEnable = 1'b0; bus.MReady = 1'b1;
        neg;
        check("r_MAddress", bus.MAddress, 32'd0);
        check("r_strobes", 32'({bus.MReadEnable, bus.MWriteEnable}), 32'd0);
        check("r_MWriteData", bus.MWriteData, 32'd0);
        check("r_IReady", 32'(bus.IReady), 32'd0);
        check("r_IBusErr", 32'(bus.IBusErr), 32'd0);
        step;
        bus.MReady = 1'b0;
        step;

        // MReady coincident with watchdog expiry: completion wins
        bus.DReadEnable = 1'b1;
        step;
        for (int k = 1; k <= T; k++) begin
            if (k == T) bus.MReady = 1'b1;
            neg;
            check("co_DReady", 32'(bus.DReady), 32'(k == T));
            check("co_DBusErr", 32'(bus.DBusErr), 32'd0);
            step;
        end
        bus.DReadEnable = 1'b0; bus.MReady = 1'b0;
        step;

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) bus.IReadEnable = ~bus.IReadEnable;
            if ($urandom_range(0, 3) == 0) bus.DReadEnable = ~bus.DReadEnable;
            if ($urandom_range(0, 3) == 0)
                bus.DWriteEnable = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            bus.IAddress = $urandom;
            bus.DAddress = $urandom;
            bus.DWriteData = $urandom;
            bus.MReadData = $urandom;
            bus.MReady = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step;
        end
        reset = 1'b0;
        bus.IReadEnable = 1'b0; bus.DReadEnable = 1'b0;
        bus.DWriteEnable = '0; bus.MReady = 1'b0;
        step;
        step;
        neg;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
